// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one classic single-beat Wishbone bus between the
// instruction-fetch port and the load/store port. Data port has fixed priority.
// One bus cycle is in flight at a time; each port gets a one-cycle done pulse.
//
// Port handshake: a port holds req_i high (with stable fields) until it sees
// done_o for one cycle; done_o with err_o = 1 means the bus timed out. busy_o
// is req_i & ~done_o and feeds the pipeline stall logic. A fetch whose request
// drops mid-cycle is flushed: the bus cycle finishes but no done is reported.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // instruction-fetch port
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_done_o,
    output logic                    if_err_o,
    output logic                    if_busy_o,
    // data-memory port
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_sel_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_done_o,
    output logic                    mem_err_o,
    output logic                    mem_busy_o,
    // Wishbone master
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic                    wb_ack_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    // debug: current arbiter state
    output logic [1:0]              dbg_state_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IF_BUS  = 2'd1;
    localparam logic [1:0] MEM_BUS = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic                  wb_we_q,     wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_adr_q,    wb_adr_d;
    logic [DATA_WIDTH-1:0] wb_dat_q,    wb_dat_d;
    logic [SEL_WIDTH-1:0]  wb_sel_q,    wb_sel_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic                  if_done_q,   if_done_d;
    logic                  if_err_q,    if_err_d;
    logic                  mem_done_q,  mem_done_d;
    logic                  mem_err_q,   mem_err_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
    logic                  discard_q,   discard_d;

    // A fetch is flushed if its request was ever low during this bus cycle,
    // including the current cycle.
    logic if_flush;
    assign if_flush = discard_q | ~if_req_i;

    // Next-state logic: grant in IDLE, then wait for ack or timeout.
    always_comb begin
        state_d     = state_q;
        wb_we_d     = wb_we_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        mem_done_d  = 1'b0;
        mem_err_d   = 1'b0;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        case (state_q)
            IDLE: begin
                // A port whose done pulse is high this cycle has not yet
                // had a chance to drop its request, so it is not eligible.
                if (mem_req_i && !mem_done_q) begin
                    state_d   = MEM_BUS;
                    wb_we_d   = mem_we_i;
                    wb_adr_d  = mem_addr_i;
                    wb_dat_d  = mem_wdata_i;
                    wb_sel_d  = mem_sel_i;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                end else if (if_req_i && !if_done_q) begin
                    state_d   = IF_BUS;
                    wb_we_d   = 1'b0;
                    wb_adr_d  = if_addr_i;
                    wb_dat_d  = '0;
                    wb_sel_d  = '1;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                end
            end
            IF_BUS: begin
                discard_d = if_flush;
                if (wb_ack_i) begin
                    state_d = IDLE;
                    if (!if_flush) begin
                        if_rdata_d = wb_dat_i;
                        if_done_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    if (!if_flush) begin
                        if_done_d = 1'b1;
                        if_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            MEM_BUS: begin
                if (wb_ack_i) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                    if (!wb_we_q) begin
                        mem_rdata_d = wb_dat_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset aborts any bus cycle silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            mem_done_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_we_q     <= wb_we_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            mem_done_q  <= mem_done_d;
            mem_err_q   <= mem_err_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
        end
    end

    assign wb_cyc_o    = (state_q != IDLE);
    assign wb_stb_o    = (state_q != IDLE);
    assign wb_we_o     = wb_we_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_sel_o    = wb_sel_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_done_o   = if_done_q;
    assign if_err_o    = if_err_q;
    assign if_busy_o   = if_req_i & ~if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign mem_err_o   = mem_err_q;
    assign mem_busy_o  = mem_req_i & ~mem_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (TIMEOUT = 4): a table of single transactions
// followed by hand-written sequences for arbitration, flush and reset.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req_i, mem_req_i, mem_we_i, wb_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, wb_dat_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_rdata_o, mem_rdata_o, wb_adr_o, wb_dat_o;
    logic        if_done_o, if_err_o, if_busy_o;
    logic        mem_done_o, mem_err_o, mem_busy_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [1:0]  dbg_state_o;

    mem_bus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_done_o  (if_done_o),
        .if_err_o   (if_err_o),
        .if_busy_o  (if_busy_o),
        .mem_req_i  (mem_req_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_sel_i  (mem_sel_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_done_o (mem_done_o),
        .mem_err_o  (mem_err_o),
        .mem_busy_o (mem_busy_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_dat_i   (wb_dat_i),
        .dbg_state_o(dbg_state_o)
    );

    // One single-port transaction: drive fields, expected bus fields and results.
    // ack_at = bus cycle (1-based) on which the slave acks; 0 = never.
    // exp_lat = cycles from request to done pulse.
    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ack_at;
        logic [31:0] slave_dat;
        int          exp_lat;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // scoreboard compare helpers
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // driver: run one table vector and check it against its record
    task automatic run_vec(input int i);
        vec_t        v;
        int          cyc_n;
        bit          got;
        bit          bus_ok;
        bit          busy_ok;
        bit          other_ok;
        logic        done;
        logic        busy;
        logic        other_done;
        logic [31:0] exp_rd;
        v = vecs[i];
        @(negedge clk);
        if (v.is_mem) begin
            mem_req_i   = 1'b1;
            mem_we_i    = v.we;
            mem_addr_i  = v.addr;
            mem_wdata_i = v.wdata;
            mem_sel_i   = v.sel;
        end else begin
            if_req_i    = 1'b1;
            if_addr_i   = v.addr;
            mem_we_i    = 1'b1;
            mem_addr_i  = 32'hFFFF_FFFF;
            mem_wdata_i = 32'hFFFF_FFFF;
            mem_sel_i   = 4'h0;
        end
        exp_q.push_back(v.is_mem ? v.exp_mem_rdata : v.exp_if_rdata);
        cyc_n    = 0;
        got      = 1'b0;
        bus_ok   = 1'b1;
        busy_ok  = 1'b1;
        other_ok = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            done       = v.is_mem ? mem_done_o : if_done_o;
            busy       = v.is_mem ? mem_busy_o : if_busy_o;
            other_done = v.is_mem ? if_done_o : mem_done_o;
            if (other_done) other_ok = 1'b0;
            if (wb_cyc_o) begin
                cyc_n++;
                if (wb_stb_o !== 1'b1 || wb_adr_o !== v.addr || wb_we_o !== v.we ||
                    wb_dat_o !== v.wdata || wb_sel_o !== v.sel) bus_ok = 1'b0;
                wb_ack_i = (cyc_n == v.ack_at);
                wb_dat_i = v.slave_dat;
            end else begin
                wb_ack_i = 1'b0;
            end
            if (done) begin
                got    = 1'b1;
                exp_rd = exp_q.pop_front();
                chk_int($sformatf("v%0d_latency", i), c, v.exp_lat);
                chk_int($sformatf("v%0d_cyc_cycles", i), cyc_n, v.exp_cyc);
                chk1($sformatf("v%0d_err", i), v.is_mem ? mem_err_o : if_err_o, v.exp_err);
                chk32($sformatf("v%0d_rdata", i), v.is_mem ? mem_rdata_o : if_rdata_o, exp_rd);
                chk32($sformatf("v%0d_if_rdata", i), if_rdata_o, v.exp_if_rdata);
                chk32($sformatf("v%0d_mem_rdata", i), mem_rdata_o, v.exp_mem_rdata);
                chk1($sformatf("v%0d_cyc_low_at_done", i), wb_cyc_o, 1'b0);
                chk1($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
                chk1($sformatf("v%0d_bus_fields", i), bus_ok, 1'b1);
                chk1($sformatf("v%0d_busy_before_done", i), busy_ok, 1'b1);
                chk1($sformatf("v%0d_other_no_done", i), other_ok, 1'b1);
                if_req_i  = 1'b0;
                mem_req_i = 1'b0;
            end else if (busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        if (!got) begin
            chk1($sformatf("v%0d_done_seen", i), 1'b0, 1'b1);
            void'(exp_q.pop_front());
            if_req_i  = 1'b0;
            mem_req_i = 1'b0;
            wb_ack_i  = 1'b0;
        end
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet_ok;
        //        mem   we    addr          wdata         sel   ack slave         lat cyc err  if_rdata      mem_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 4'hF, 3, 32'h0000_0013, 4, 3, 1'b0, 32'h0000_0013, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_2000, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 2, 1, 1'b0, 32'h0000_0013, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 2, 32'hFFFF_0000, 3, 2, 1'b0, 32'h0000_0013, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h8000_3000, 32'h0000_0000, 4'hC, 0, 32'h0BAD_0BAD, 5, 4, 1'b1, 32'h0000_0013, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0000_0000, 4'hF, 4, 32'hCAFE_F00D, 5, 4, 1'b0, 32'hCAFE_F00D, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_2004, 32'h0000_0000, 4'h1, 3, 32'hA5A5_0001, 4, 3, 1'b0, 32'hCAFE_F00D, 32'hA5A5_0001};
        vecs[6] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0000_0000, 4'hF, 0, 32'h7777_7777, 5, 4, 1'b1, 32'hCAFE_F00D, 32'hA5A5_0001};

        reset       = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_sel_i   = '0;
        wb_ack_i    = 1'b0;
        wb_dat_i    = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk1("rst_cyc", wb_cyc_o, 1'b0);
        chk1("rst_stb", wb_stb_o, 1'b0);
        chk1("rst_we", wb_we_o, 1'b0);
        chk32("rst_adr", wb_adr_o, 32'h0);
        chk32("rst_dat", wb_dat_o, 32'h0);
        chk32("rst_sel", 32'(wb_sel_o), 32'h0);
        chk32("rst_if_rdata", if_rdata_o, 32'h0);
        chk32("rst_mem_rdata", mem_rdata_o, 32'h0);
        chk1("rst_if_done", if_done_o, 1'b0);
        chk1("rst_mem_done", mem_done_o, 1'b0);
        chk1("rst_if_err", if_err_o, 1'b0);
        chk1("rst_mem_err", mem_err_o, 1'b0);
        chk32("rst_state", 32'(dbg_state_o), 32'h0);
        reset = 1'b0;

        // table of single transactions
        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // simultaneous requests: mem store first, then IF fetch
        @(negedge clk);
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_addr_i  = 32'h8000_1000;
        mem_wdata_i = 32'hDEAD_BEEF;
        mem_sel_i   = 4'h3;
        if_req_i    = 1'b1;
        if_addr_i   = 32'h8000_0100;
        @(negedge clk);
        chk1("sim_cyc1", wb_cyc_o, 1'b1);
        chk1("sim_we1", wb_we_o, 1'b1);
        chk32("sim_adr1", wb_adr_o, 32'h8000_1000);
        chk32("sim_dat1", wb_dat_o, 32'hDEAD_BEEF);
        chk32("sim_sel1", 32'(wb_sel_o), 32'h3);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("sim_mem_done", mem_done_o, 1'b1);
        chk1("sim_mem_err", mem_err_o, 1'b0);
        chk1("sim_if_done_early", if_done_o, 1'b0);
        chk1("sim_cyc_gap", wb_cyc_o, 1'b0);
        chk1("sim_if_busy", if_busy_o, 1'b1);
        chk1("sim_mem_busy", mem_busy_o, 1'b0);
        chk32("sim_store_no_capture", mem_rdata_o, 32'hA5A5_0001);
        mem_req_i = 1'b0;
        @(negedge clk);
        chk1("sim_cyc2", wb_cyc_o, 1'b1);
        chk1("sim_we2", wb_we_o, 1'b0);
        chk32("sim_adr2", wb_adr_o, 32'h8000_0100);
        chk32("sim_dat2", wb_dat_o, 32'h0);
        chk32("sim_sel2", 32'(wb_sel_o), 32'hF);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0093;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("sim_if_done", if_done_o, 1'b1);
        chk1("sim_if_err", if_err_o, 1'b0);
        chk32("sim_if_rdata", if_rdata_o, 32'h0000_0093);
        if_req_i = 1'b0;

        // IF flush: request drops after grant, new fetch raised meanwhile
        @(negedge clk);
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0200;
        @(negedge clk);
        chk1("fl_cyc1", wb_cyc_o, 1'b1);
        chk32("fl_adr1", wb_adr_o, 32'h8000_0200);
        if_req_i = 1'b0;
        @(negedge clk);
        chk1("fl_no_done_a", if_done_o, 1'b0);
        if_req_i  = 1'b1;
        if_addr_i = 32'h8000_0300;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 32'h0000_0BAD;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("fl_cyc_gap", wb_cyc_o, 1'b0);
        chk1("fl_no_done_b", if_done_o, 1'b0);
        chk1("fl_busy", if_busy_o, 1'b1);
        @(negedge clk);
        chk1("fl_cyc2", wb_cyc_o, 1'b1);
        chk32("fl_adr2", wb_adr_o, 32'h8000_0300);
        chk1("fl_no_done_c", if_done_o, 1'b0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0037;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk1("fl_done", if_done_o, 1'b1);
        chk1("fl_err", if_err_o, 1'b0);
        chk32("fl_rdata", if_rdata_o, 32'h0000_0037);
        if_req_i = 1'b0;

        // reset in the middle of a bus cycle
        @(negedge clk);
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h8000_4000;
        mem_sel_i  = 4'hF;
        @(negedge clk);
        chk1("mr_cyc_before", wb_cyc_o, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("mr_cyc", wb_cyc_o, 1'b0);
        chk1("mr_stb", wb_stb_o, 1'b0);
        chk32("mr_adr", wb_adr_o, 32'h0);
        chk32("mr_sel", 32'(wb_sel_o), 32'h0);
        chk32("mr_if_rdata", if_rdata_o, 32'h0);
        chk32("mr_mem_rdata", mem_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        quiet_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_done_o !== 1'b0 || if_done_o !== 1'b0 || wb_cyc_o !== 1'b0) quiet_ok = 1'b0;
        end
        chk1("mr_no_done_after", quiet_ok, 1'b1);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the single Wishbone (classic, single-beat) memory bus between the instruction-fetch port and the data-memory (load/store) port of the 5-stage pipeline. It latches each granted request, runs one bus cycle at a time with fixed data-port priority, and returns read data and a one-cycle done pulse. It also generates the per-port busy flags that feed the pipeline stall/flush controller's `im` and `mem` inputs. A bus timeout prevents a missing slave from hanging the pipeline.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the bus
- DATA_WIDTH, 32, data width; byte-select width is DATA_WIDTH/8
- TIMEOUT, 255, cycles a bus cycle may wait for ack before abort (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, level
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_rdata_o  out  DATA_WIDTH  fetched word
- if_done_o  out  1  one-cycle completion pulse
- if_err_o  out  1  with if_done_o: timed out
- if_busy_o  out  1  if_req_i & ~if_done_o (combinational)
- mem_req_i  in  1  data request, level
- mem_we_i  in  1  1 = store
- mem_addr_i  in  ADDR_WIDTH  data address
- mem_wdata_i  in  DATA_WIDTH  store data
- mem_sel_i  in  DATA_WIDTH/8  byte enables
- mem_rdata_o  out  DATA_WIDTH  load data
- mem_done_o  out  1  one-cycle completion pulse
- mem_err_o  out  1  with mem_done_o: timed out
- mem_busy_o  out  1  mem_req_i & ~mem_done_o (combinational)
- wb_cyc_o, wb_stb_o  out  1  bus cycle/strobe, driven identically
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_WIDTH  bus address
- wb_dat_o  out  DATA_WIDTH  write data
- wb_sel_o  out  DATA_WIDTH/8  byte selects
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  DATA_WIDTH  slave read data

## Operation
- States: IDLE, IF_BUS, MEM_BUS.
- IDLE: a port is eligible when its req_i = 1 and its done_o is not high this cycle. If mem is eligible, go to MEM_BUS; else if IF is eligible, go to IF_BUS.
- On grant, register the port's address, we, wdata and sel into wb_*_o. IF always uses we=0, sel=all ones and wdata=0. Clear the timeout counter and clear the discard flag.
- While in a bus state, wb_cyc_o = wb_stb_o = 1 and all wb_*_o are held stable.
- On ack:
  - Capture wb_dat_i into the granted port's rdata_o, but only for reads.
  - Pulse that port's done_o next cycle with err=0 and return to IDLE.
  - The other port's rdata_o is untouched. rdata_o holds until that port's next read completion.
- Timeout: the counter increments each bus cycle without ack. The cycle it equals TIMEOUT−1 with no ack, abort: return to IDLE, pulse done_o with err_o=1, leave rdata_o unchanged. If ack and timeout occur in the same cycle, ack wins.
- IF flush: if if_req_i = 0 in any IF_BUS cycle, set the discard flag. The bus cycle still completes normally, but if_done_o/if_err_o are suppressed. A new if_req_i raised meanwhile is served after return to IDLE.
- mem_req_i must stay high with stable fields until mem_done_o. If it drops early, the transaction still completes and mem_done_o still pulses.
- Fixed priority: mem over IF. Two simultaneous requests in IDLE give MEM then IF.

## Timing
- Reset (async): state IDLE; wb_cyc_o/wb_stb_o/wb_we_o = 0; wb_adr_o/wb_dat_o/wb_sel_o = 0; both rdata_o = 0; done_o and err_o = 0; counter and discard flag = 0.
- Reset while in a bus state drops wb_cyc_o immediately, with no done pulse.
- Request seen in IDLE at cycle t → wb_cyc_o high at t+1.
- Ack at cycle k → wb_cyc_o low, done_o high and rdata_o valid at k+1.
- Minimum latency (ack at t+1): req at t → done at t+2.
- After completion, the other port's pending request is granted at k+1, giving wb_cyc_o at k+2.
- The same port re-requesting is granted at k+2 at the earliest, giving wb_cyc_o at k+3.
- wb_cyc_o is never high in two consecutive transactions without at least one low cycle between them.
- Timeout with no ack: wb_cyc_o is high for exactly TIMEOUT cycles; done_o/err_o pulse the following cycle.
- busy_o is high from the cycle req_i rises until the cycle done_o pulses. It is low in the done cycle.

## Test plan
- Single IF read: if_req_i at t, addr 0x8000_0000, slave acks at t+3 with 0x0000_0013 → wb_adr_o 0x8000_0000, we=0, sel=0xF during t+1..t+3; if_done_o and if_rdata_o=0x13 at t+4; if_busy_o high t..t+3.
- Simultaneous requests: both at t, mem store 0x8000_1000/0xDEAD_BEEF/sel 0x3, slave acks in 1 cycle → store cycle t+1, mem_done_o at t+2, IF cycle at t+3, if_done_o at t+4.
- Timeout: TIMEOUT=4, mem load, no ack → wb_cyc_o high exactly 4 cycles; mem_done_o=mem_err_o=1 the next cycle; mem_rdata_o unchanged.
- IF flush: if_req_i drops the cycle after grant, then rises with a new address → old cycle completes, no if_done_o for it; new fetch is granted after IDLE and gets its own if_done_o.
- Reset mid-cycle: assert reset while wb_cyc_o=1 → wb_cyc_o low within the same cycle, no done pulse, all outputs at reset values.
- Ack and timeout in the same cycle (TIMEOUT=2, ack on the 2nd cycle) → done=1, err=0, rdata captured.
